// File: rtl/bs_mc_accum.sv
// rtl/bs_mc_accum.sv - Monte Carlo payoff accumulator: issues sample requests, sums clamped payoffs and squares.
// Optional macro BS_ACC_SAT_EN: saturate accumulators instead of wrapping.
module bs_mc_accum #(
    parameter int DATA_W = 32,
    parameter int FRAC_W = 20,
    parameter int ACC_W  = 64,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [3:0]        cmd,
    input  logic [CNT_W-1:0]  niter,
    output logic              issue_valid,
    input  logic              issue_ready,
    input  logic              sample_valid,
    input  logic [DATA_W-1:0] sample_data,
    output logic [3:0]        status,
    output logic [ACC_W-1:0]  sum_out,
    output logic [ACC_W-1:0]  sumsq_out,
    output logic              ovf
);

    localparam int SQ_W   = 2 * DATA_W;
    localparam int WIDE_W = ((ACC_W > SQ_W) ? ACC_W : SQ_W) + 1;

    localparam logic [3:0] CMD_RUN   = 4'd1;
    localparam logic [3:0] CMD_ACK   = 4'd2;
    localparam logic [3:0] CMD_ABORT = 4'd3;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_RUNNING  = 2'd1,
        S_COMPLETE = 2'd2,
        S_DRAIN    = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   niter_q, niter_d;
    logic [CNT_W-1:0]   issued_q, issued_d;
    logic [CNT_W-1:0]   received_q, received_d;
    logic [ACC_W-1:0]   sum_q, sum_d;
    logic [ACC_W-1:0]   sumsq_q, sumsq_d;
    logic               ovf_q, ovf_d;

    logic [DATA_W-1:0]  clamped;
    logic [SQ_W-1:0]    clamp_ext;
    logic [SQ_W-1:0]    sq_full;
    logic [SQ_W-1:0]    sq_shr;
    logic [WIDE_W-1:0]  sum_wide;
    logic [WIDE_W-1:0]  sumsq_wide;
    logic               sum_of;
    logic               sumsq_of;
    logic [ACC_W-1:0]   sum_nxt;
    logic [ACC_W-1:0]   sumsq_nxt;
    logic [CNT_W-1:0]   issued_inc;
    logic [CNT_W-1:0]   received_inc;
    logic               handshake;
    logic               accept;

    assign issue_valid = (state_q == S_RUNNING) && (issued_q < niter_q);
    assign handshake   = issue_valid && issue_ready;
    // Samples with no request outstanding are stray and dropped.
    assign accept      = sample_valid && (received_q != issued_q) &&
                         ((state_q == S_RUNNING) || (state_q == S_DRAIN));

    assign issued_inc   = issued_q + {{(CNT_W-1){1'b0}}, 1'b1};
    assign received_inc = received_q + {{(CNT_W-1){1'b0}}, 1'b1};

    always_comb begin
        clamped    = sample_data[DATA_W-1] ? '0 : sample_data;
        clamp_ext  = {{DATA_W{1'b0}}, clamped};
        sq_full    = clamp_ext * clamp_ext;
        sq_shr     = sq_full >> FRAC_W;
        // Sums are formed one bit wider than any operand so overflow is never lost.
        sum_wide   = {{(WIDE_W-ACC_W){1'b0}}, sum_q} + {{(WIDE_W-DATA_W){1'b0}}, clamped};
        sumsq_wide = {{(WIDE_W-ACC_W){1'b0}}, sumsq_q} + {{(WIDE_W-SQ_W){1'b0}}, sq_shr};
        sum_of     = |sum_wide[WIDE_W-1:ACC_W];
        sumsq_of   = |sumsq_wide[WIDE_W-1:ACC_W];
`ifdef BS_ACC_SAT_EN
        sum_nxt    = sum_of   ? {ACC_W{1'b1}} : sum_wide[ACC_W-1:0];
        sumsq_nxt  = sumsq_of ? {ACC_W{1'b1}} : sumsq_wide[ACC_W-1:0];
`else
        sum_nxt    = sum_wide[ACC_W-1:0];
        sumsq_nxt  = sumsq_wide[ACC_W-1:0];
`endif
    end

    always_comb begin
        state_d    = state_q;
        niter_d    = niter_q;
        issued_d   = issued_q;
        received_d = received_q;
        sum_d      = sum_q;
        sumsq_d    = sumsq_q;
        ovf_d      = ovf_q;
        case (state_q)
            S_IDLE: begin
                if (cmd == CMD_RUN) begin
                    niter_d    = niter;
                    issued_d   = '0;
                    received_d = '0;
                    sum_d      = '0;
                    sumsq_d    = '0;
                    ovf_d      = 1'b0;
                    state_d    = (niter == '0) ? S_COMPLETE : S_RUNNING;
                end
            end
            S_RUNNING, S_DRAIN: begin
                if (cmd == CMD_ABORT) begin
                    issued_d   = '0;
                    received_d = '0;
                    state_d    = S_IDLE;
                end else begin
                    if (handshake) begin
                        issued_d = issued_inc;
                        if (issued_inc == niter_q) begin
                            state_d = S_DRAIN;
                        end
                    end
                    if (accept) begin
                        received_d = received_inc;
                        sum_d      = sum_nxt;
                        sumsq_d    = sumsq_nxt;
                        ovf_d      = ovf_q | sum_of | sumsq_of;
                        if (received_inc == niter_q) begin
                            state_d = S_COMPLETE;
                        end
                    end
                end
            end
            S_COMPLETE: begin
                if (cmd == CMD_ACK) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            niter_q    <= '0;
            issued_q   <= '0;
            received_q <= '0;
            sum_q      <= '0;
            sumsq_q    <= '0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            niter_q    <= niter_d;
            issued_q   <= issued_d;
            received_q <= received_d;
            sum_q      <= sum_d;
            sumsq_q    <= sumsq_d;
            ovf_q      <= ovf_d;
        end
    end

    assign status    = {2'b00, state_q};
    assign sum_out   = sum_q;
    assign sumsq_out = sumsq_q;
    assign ovf       = ovf_q;

endmodule
